csr_unit: RTL
=============

# csr_unit

Sequencer that executes Zicsr instructions (CSRRW/RS/RC and immediate forms) against the machine-mode CSR file. It sits between the execute stage and the `CSRs` block, driving the CSR file's `csr_w`/`csr_addr`/`csr_din` write port and consuming its combinational `csr_dout` read port. Each request runs a read–modify–write sequence, returns the pre-write value for `rd`, and flags illegal accesses.

## Interface
- `XLEN`, default 32: data width; must match the `CSRs` instance.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rstl`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `req_funct3`  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `req_addr`  in  12  CSR address.
- `req_rs1`  in  5  rs1 index, or zimm for the immediate forms.
- `req_rs1_val`  in  XLEN  rs1 register value.
- `req_rd`  in  5  destination register index.
- `resp_valid`  out  1  response held until accepted.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rd`  out  5  latched `req_rd`.
- `resp_data`  out  XLEN  CSR value before the write.
- `resp_we`  out  1  `rd != 0` and not illegal.
- `resp_illegal`  out  1  illegal-instruction indication.
- `csr_w`  out  1  CSR write strobe; the write commits on the rising edge while high.
- `csr_addr`  out  12  CSR address.
- `csr_din`  out  XLEN  CSR write data.
- `csr_dout`  in  XLEN  CSR read data, combinational from `csr_addr`.

## Operation
- **FSM:** IDLE → READ → WRITE → RESP → IDLE.
- **IDLE:** when `req_valid`, latch all request fields and go to READ.
- **READ:** `csr_addr` = latched address; `old` ← `csr_dout` at end of cycle.
- **WRITE:** `csr_w` = `wen`; `csr_din` = `new`.
- **RESP:** stay until `resp_ready`.
- **Source operand:** `src` = `funct3[2]` ? zero-extended zimm : `rs1_val`.
- **New value:**
  - RW: `new` = `src`
  - RS: `new` = `old | src`
  - RC: `new` = `old & ~src`
- **Write enable:** `wen` = legal and (RW/RWI, or `req_rs1 != 0`). For RS/RC/RSI/RCI with `rs1`/zimm == 0, no write is performed. An RW with `rd == 0` still reads; this is harmless because the CSRs have no read side effects.
- **Illegal** when any of:
  - `funct3` ∈ {000, 100};
  - the address is not implemented;
  - a write is attempted (`wen` before the legality gate) to `addr[11:10] == 2'b11`.
- **Implemented addresses:** F11, F12, F13, F14, 300, 301, 304, 305, 340, 341, 342, 343, 344.
- **Illegal requests** still traverse all states. `csr_w` stays 0, `resp_illegal` = 1, `resp_we` = 0, `resp_data` = 0.
- **WARL masking** belongs to the CSR file. `resp_data` is the raw `old` value.

## Timing
- **Accept:** at edge N when IDLE and `req_valid`.
  - READ occupies cycle N+1.
  - WRITE occupies N+2; the write commits at edge N+3.
  - `resp_valid` rises after edge N+3.
  - Latency is fixed at 3 cycles. Minimum request spacing is 4 cycles.
- **Backpressure:** while `resp_valid` && !`resp_ready`, all `resp_*` outputs hold stable and `req_valid` is ignored.
- **Response/request overlap:** `resp_ready` accepted at edge M returns to IDLE. A new request can be accepted at edge M+1 at the earliest, because `req_ready` is a decode of IDLE.
- **Output hold:** `csr_addr` and `csr_din` come from registers and hold their last values outside READ/WRITE. `csr_w` is high only in WRITE, and only when `wen`.
- **Reset values:**
  - state IDLE, so `req_ready` = 1;
  - `resp_valid`, `resp_we`, `resp_illegal`, `csr_w` = 0;
  - `resp_rd`, `resp_data`, `csr_addr`, `csr_din`, `old` = 0.
- **Reset mid-operation:** asserting `rstl` forces IDLE immediately and drops `csr_w` combinationally. A write not yet committed is lost, and any pending response is discarded.

## Structure
- **Package `csr_pkg`:**
  - localparams for every CSR address listed above;
  - enum for `funct3` encodings;
  - enum for FSM states;
  - function `csr_implemented(addr)`.

  The address constants replace any ad-hoc string-to-address maps, so benches share the same package.
- **Sub-module `csr_alu`:** combinational (`funct3`, `old`, `src`) → `new`. Instantiated once.
- **Top level:** `csr_unit` holds the FSM, the request latch, and the legality logic.

## Test plan
1. **Reset.** Pulse `rstl` low → `req_ready` = 1, `resp_valid` = 0, `csr_w` = 0 with no clock edge required.
2. **CSRRW and read-back.** CSRRW 0x340, `rs1_val` = 0xDEADBEEF, `rd` = 5 →
   - `csr_w` is high for exactly one cycle, in cycle 2 after accept, with `csr_din` = 0xDEADBEEF;
   - `resp_valid` after 3 cycles, `resp_data` = 0, `resp_we` = 1, `resp_rd` = 5;
   - a following CSRRS 0x340 with `rs1` = x0 → `resp_data` = 0xDEADBEEF and `csr_w` never asserted.
3. **CSRRCI.** CSRRCI 0x340, zimm = 0x0F, with value 0xDEADBEEF → `csr_din` = 0xDEADBEE0, `resp_data` = 0xDEADBEEF.
4. **Read-only CSRs.**
   - CSRRW 0xF14 → `resp_illegal` = 1, `resp_we` = 0, `csr_w` never high.
   - CSRRS 0x301 with `rs1` = x0, XLEN = 32 → legal, `resp_data` = 0x40000100.
5. **Other illegal encodings.** Address 0x7C0, and `funct3` = 100 on 0x340 → both give `resp_illegal` = 1; mscratch is unchanged, verified by read-back.
6. **Backpressure and reset during WRITE.**
   - Hold `resp_ready` = 0 for 5 cycles → `resp_*` stable, `req_ready` = 0, and a concurrent `req_valid` is dropped.
   - Assert `rstl` during WRITE of CSRRW 0x340 = 0x12345678 → `csr_w` falls immediately, and mscratch keeps its prior value.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// csr_pkg : machine-mode CSR addresses, Zicsr funct3 codes, sequencer states
// Revision: 1.0
// ============================================================================
package csr_pkg;

    localparam logic [11:0] c_CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] c_CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] c_CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] c_CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] c_CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] c_CSR_MISA      = 12'h301;
    localparam logic [11:0] c_CSR_MIE       = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] c_CSR_MEPC      = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL     = 12'h343;
    localparam logic [11:0] c_CSR_MIP       = 12'h344;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    function automatic logic csr_implemented(input logic [11:0] addr);
        case (addr)
            c_CSR_MVENDORID, c_CSR_MARCHID, c_CSR_MIMPID, c_CSR_MHARTID,
            c_CSR_MSTATUS, c_CSR_MISA, c_CSR_MIE, c_CSR_MTVEC,
            c_CSR_MSCRATCH, c_CSR_MEPC, c_CSR_MCAUSE, c_CSR_MTVAL,
            c_CSR_MIP:  return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_alu.sv
`default_nettype none
// ============================================================================
// csr_alu : combinational new-value computation for CSRRW/RS/RC (+ immediate)
// Revision: 1.0
// ============================================================================
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] src_i,
    output logic [XLEN-1:0] new_o
);

    always_comb begin
        new_o = src_i;
        case (funct3_i)
            F3_RS, F3_RSI: new_o = old_i | src_i;
            F3_RC, F3_RCI: new_o = old_i & ~src_i;
            default:       new_o = src_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// csr_unit : Zicsr read-modify-write sequencer in front of the M-mode CSR file
// Revision: 1.0
// ============================================================================
module csr_unit
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstl,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_we,
    output logic            resp_illegal,
    output logic            csr_w,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_din,
    input  logic [XLEN-1:0] csr_dout
);

    csr_state_e      state_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] old_q;
    logic [11:0]     csr_addr_q;
    logic [XLEN-1:0] csr_din_q;
    logic            csr_w_q;
    logic            resp_valid_q;
    logic            resp_we_q;
    logic            resp_illegal_q;
    logic [4:0]      resp_rd_q;
    logic [XLEN-1:0] resp_data_q;

    logic [XLEN-1:0] w_src;
    logic [XLEN-1:0] csr_din_d;
    logic            w_f3_bad;
    logic            w_wr_attempt;
    logic            w_illegal;
    logic            w_wen;

    // Legality is decoded from the latched request, so it is stable from READ onward.
    assign w_src        = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_q} : rs1_val_q;
    assign w_f3_bad     = (funct3_q[1:0] == 2'b00);
    assign w_wr_attempt = (funct3_q[1:0] == 2'b01) || (rs1_q != 5'd0);
    assign w_illegal    = w_f3_bad || !csr_implemented(csr_addr_q)
                          || (w_wr_attempt && (csr_addr_q[11:10] == 2'b11));
    assign w_wen        = w_wr_attempt && !w_illegal;

    // csr_dout is only sampled in READ, where it is the pre-write value.
    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3_i (funct3_q),
        .old_i    (csr_dout),
        .src_i    (w_src),
        .new_o    (csr_din_d)
    );

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            state_q        <= ST_IDLE;
            funct3_q       <= 3'd0;
            rs1_q          <= 5'd0;
            rd_q           <= 5'd0;
            rs1_val_q      <= '0;
            old_q          <= '0;
            csr_addr_q     <= 12'd0;
            csr_din_q      <= '0;
            csr_w_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_we_q      <= 1'b0;
            resp_illegal_q <= 1'b0;
            resp_rd_q      <= 5'd0;
            resp_data_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        csr_addr_q <= req_addr;
                        rs1_q      <= req_rs1;
                        rs1_val_q  <= req_rs1_val;
                        rd_q       <= req_rd;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q   <= csr_dout;
                    csr_w_q <= w_wen;
                    if (w_wen) begin
                        csr_din_q <= csr_din_d;
                    end
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    csr_w_q        <= 1'b0;
                    resp_valid_q   <= 1'b1;
                    resp_rd_q      <= rd_q;
                    resp_data_q    <= w_illegal ? '0 : old_q;
                    resp_we_q      <= !w_illegal && (rd_q != 5'd0);
                    resp_illegal_q <= w_illegal;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign csr_w        = csr_w_q;
    assign csr_addr     = csr_addr_q;
    assign csr_din      = csr_din_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rd      = resp_rd_q;
    assign resp_data    = resp_data_q;
    assign resp_we      = resp_we_q;
    assign resp_illegal = resp_illegal_q;

endmodule
`default_nettype wire
